// File: rtl/ras_predictor_pkg.sv
// Shared types for the return address stack predictor.
// Port summary: none (package). Provides id_t, branch_results_t,
// ras_ptr_t and ras_checkpoint_t sized for the default configuration.
package ras_predictor_pkg;

    localparam int RAS_DEPTH_DEF = 8;
    localparam int MAX_IDS_DEF   = 8;

    localparam int ID_W  = $clog2(MAX_IDS_DEF);
    localparam int PTR_W = $clog2(RAS_DEPTH_DEF);
    localparam int CNT_W = $clog2(RAS_DEPTH_DEF + 1);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        id_t         id;
        logic        valid;
        logic [31:0] pc;
        logic        is_call;
        logic        is_return;
    } branch_results_t;

    typedef logic [PTR_W-1:0] ras_ptr_t;

    typedef struct packed {
        ras_ptr_t          tos;
        logic [CNT_W-1:0]  count;
    } ras_checkpoint_t;

endpackage

// File: rtl/ras_predictor_checkpoint_table.sv
// Per-instruction-id snapshot of the stack pointer state {tos, count}.
// Ports: clk, we/waddr/wdata (one synchronous write), raddr/rdata
// (one asynchronous read). Contents are intentionally not reset.
module ras_checkpoint_table #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 3,
    parameter int WIDTH   = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ras_predictor.sv
// Return address stack with per-id checkpoints for misprediction recovery.
// Ports: clk/rst, fetch_* (speculative push/pop tagged by fetch_id),
// ras_addr/ras_valid (top of stack), br_results/branch_flush (recovery).
module ras_predictor
    import ras_predictor_pkg::*;
#(
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int MAX_IDS   = MAX_IDS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  id_t             fetch_id,
    input  logic            fetch_push,
    input  logic [31:0]     fetch_push_addr,
    input  logic            fetch_pop,
    output logic [31:0]     ras_addr,
    output logic            ras_valid,
    input  branch_results_t br_results,
    input  logic            branch_flush
);

    localparam int P_W    = $clog2(RAS_DEPTH);
    localparam int C_W    = P_W + 1;
    localparam int CKPT_W = P_W + C_W;
    localparam logic [C_W-1:0] FULL = C_W'(RAS_DEPTH);

    logic [31:0]      storage_q [RAS_DEPTH];
    logic [P_W-1:0]   tos_q, tos_d, base_tos;
    logic [C_W-1:0]   count_q, count_d, base_cnt;
    logic [CKPT_W-1:0] ckpt_rd;

    logic             recover;
    logic             do_push, do_pop;
    logic [31:0]      push_addr;
    logic             wr_en;
    logic [P_W-1:0]   wr_idx;

    // A flush replaces the fetch-side operation entirely, including its checkpoint.
    assign recover = br_results.valid & branch_flush;

    ras_checkpoint_table #(
        .ENTRIES (MAX_IDS),
        .ADDR_W  (ID_W),
        .WIDTH   (CKPT_W)
    ) u_ckpt (
        .clk   (clk),
        .we    (fetch_valid & ~recover & ~rst),
        .waddr (fetch_id),
        .wdata ({tos_q, count_q}),
        .raddr (br_results.id),
        .rdata (ckpt_rd)
    );

    always_comb begin
        base_tos  = tos_q;
        base_cnt  = count_q;
        do_push   = fetch_valid & fetch_push;
        do_pop    = fetch_valid & fetch_pop;
        push_addr = fetch_push_addr;
        if (recover) begin
            {base_tos, base_cnt} = ckpt_rd;
            do_push   = br_results.is_call;
            do_pop    = br_results.is_return;
            push_addr = br_results.pc + 32'd4;
        end

        tos_d   = base_tos;
        count_d = base_cnt;
        wr_en   = 1'b0;
        wr_idx  = base_tos;
        if (do_push && do_pop) begin
            // Call and return in one step: replace the top in place.
            wr_en = 1'b1;
            if (base_cnt == '0) begin
                count_d = C_W'(1);
            end
        end else if (do_push) begin
            // At full the pointer simply wraps onto the oldest entry.
            tos_d  = base_tos + P_W'(1);
            wr_idx = base_tos + P_W'(1);
            wr_en  = 1'b1;
            if (base_cnt != FULL) begin
                count_d = base_cnt + C_W'(1);
            end
        end else if (do_pop) begin
            if (base_cnt != '0) begin
                tos_d   = base_tos - P_W'(1);
                count_d = base_cnt - C_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    // Storage is never reset; wrong-path overwrites are not undone on recovery.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            storage_q[wr_idx] <= push_addr;
        end
    end

    assign ras_addr  = storage_q[tos_q];
    assign ras_valid = (count_q != '0);

endmodule

// File: tb/tb_ras_predictor.sv
module tb_ras_predictor;
    import ras_predictor_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_valid;
    id_t             fetch_id;
    logic            fetch_push;
    logic [31:0]     fetch_push_addr;
    logic            fetch_pop;
    logic [31:0]     ras_addr;
    logic            ras_valid;
    branch_results_t br_results;
    logic            branch_flush;

    int total = 0;
    int bad   = 0;

    ras_predictor #(.RAS_DEPTH(8), .MAX_IDS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_id        (fetch_id),
        .fetch_push      (fetch_push),
        .fetch_push_addr (fetch_push_addr),
        .fetch_pop       (fetch_pop),
        .ras_addr        (ras_addr),
        .ras_valid       (ras_valid),
        .br_results      (br_results),
        .branch_flush    (branch_flush)
    );

    always #5 clk = ~clk;

    task automatic clr();
        rst             = 1'b0;
        fetch_valid     = 1'b0;
        fetch_id        = '0;
        fetch_push      = 1'b0;
        fetch_push_addr = '0;
        fetch_pop       = 1'b0;
        br_results      = '0;
        branch_flush    = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fetch(input int id, input logic push, input logic [31:0] addr, input logic pop);
        fetch_valid     = 1'b1;
        fetch_id        = id_t'(id);
        fetch_push      = push;
        fetch_push_addr = addr;
        fetch_pop       = pop;
    endtask

    task automatic set_br(input int id, input logic flush, input logic call, input logic ret,
                          input logic [31:0] pc);
        br_results.valid     = 1'b1;
        br_results.id        = id_t'(id);
        br_results.is_call   = call;
        br_results.is_return = ret;
        br_results.pc        = pc;
        branch_flush         = flush;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        clr();
        rst = 1'b1;
        cyc();
        check("reset_valid", {31'd0, ras_valid}, 32'd0);
        check("reset_count", 32'(dut.count_q), 32'd0);
        check("reset_tos",   32'(dut.tos_q),   32'd0);

        // Two pushes from empty
        set_fetch(0, 1, 32'h100, 0); cyc();
        check("push1_addr", ras_addr, 32'h100);
        check("push1_valid", {31'd0, ras_valid}, 32'd1);
        set_fetch(1, 1, 32'h200, 0); cyc();
        check("push2_addr", ras_addr, 32'h200);
        check("push2_count", 32'(dut.count_q), 32'd2);

        // Correct prediction resolving: no state change
        set_br(0, 0, 1, 1, 32'h4000); cyc();
        check("noflush_addr",  ras_addr, 32'h200);
        check("noflush_count", 32'(dut.count_q), 32'd2);
        check("noflush_tos",   32'(dut.tos_q),   32'd2);

        // Push+pop in the same cycle
        do_reset();
        set_fetch(0, 1, 32'h44, 1); cyc();
        check("pp_empty_count", 32'(dut.count_q), 32'd1);
        check("pp_empty_addr",  ras_addr, 32'h44);
        set_fetch(1, 1, 32'h11, 0); cyc();
        set_fetch(2, 1, 32'h22, 0); cyc();
        set_fetch(3, 1, 32'h55, 1); cyc();
        check("pp3_count", 32'(dut.count_q), 32'd3);
        check("pp3_addr",  ras_addr, 32'h55);
        check("pp3_tos",   32'(dut.tos_q), 32'd2);
        set_fetch(4, 0, 32'h0, 1); cyc();
        check("pp3_pop_addr", ras_addr, 32'h11);

        // Overflow then drain
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_fetch(i % 8, 1, 32'h10 * (i + 1), 0); cyc();
        end
        check("full_count", 32'(dut.count_q), 32'd8);
        check("full_addr",  ras_addr, 32'h90);
        check("full_tos",   32'(dut.tos_q), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_addr%0d", i), ras_addr, 32'h90 - 32'h10 * i);
            set_fetch(i, 0, 32'h0, 1); cyc();
        end
        check("drain_valid", {31'd0, ras_valid}, 32'd0);
        check("drain_count", 32'(dut.count_q), 32'd0);
        check("drain_tos",   32'(dut.tos_q), 32'd1);
        set_fetch(0, 0, 32'h0, 1); cyc();
        check("underflow_count", 32'(dut.count_q), 32'd0);
        check("underflow_tos",   32'(dut.tos_q), 32'd1);

        // Recovery with a return
        do_reset();
        set_fetch(1, 1, 32'h100, 0); cyc();
        set_fetch(2, 0, 32'h0, 1);   cyc();
        set_fetch(3, 1, 32'h300, 0); cyc();
        check("spec_addr",  ras_addr, 32'h300);
        check("spec_count", 32'(dut.count_q), 32'd1);
        set_br(2, 1, 0, 1, 32'h0); cyc();
        check("flush_ret_count", 32'(dut.count_q), 32'd0);
        check("flush_ret_valid", {31'd0, ras_valid}, 32'd0);
        check("flush_ret_tos",   32'(dut.tos_q), 32'd0);

        // Recovery with a call overrides a simultaneous fetch push and checkpoint write
        set_br(1, 1, 1, 0, 32'h1000);
        set_fetch(1, 1, 32'h500, 0);
        cyc();
        check("flush_call_addr",  ras_addr, 32'h1004);
        check("flush_call_count", 32'(dut.count_q), 32'd1);
        set_br(1, 1, 1, 0, 32'h2000); cyc();
        check("ckpt_kept_count", 32'(dut.count_q), 32'd1);
        check("ckpt_kept_addr",  ras_addr, 32'h2004);

        // Recovery with no resolved op restores pointers only
        set_br(3, 1, 0, 0, 32'h0); cyc();
        check("flush_none_count", 32'(dut.count_q), 32'd0);
        check("flush_none_tos",   32'(dut.tos_q), 32'd0);

        // Reset overrides a same-cycle push
        set_fetch(0, 1, 32'h700, 0); cyc();
        check("pre_rst_count", 32'(dut.count_q), 32'd1);
        set_fetch(1, 1, 32'h800, 0);
        rst = 1'b1;
        cyc();
        check("mid_rst_count", 32'(dut.count_q), 32'd0);
        check("mid_rst_valid", {31'd0, ras_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ras_predictor.md
RAS_PREDICTOR -- requirements
Module: ras_predictor

Interface
REQ-001 SHALL have parameter RAS_DEPTH, default 8, number of stack entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_IDS, default 8, number of in-flight instruction ids (width of id_t).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fetch_valid  input  1  a fetch-stage instruction is being accepted this cycle and is tagged with fetch_id.
REQ-006 fetch_id  input  id_t  id of the accepted fetch instruction.
REQ-007 fetch_push  input  1  predicted call: push fetch_push_addr; qualified by fetch_valid.
REQ-008 fetch_push_addr  input  32  return address for the predicted call (pc+4).
REQ-009 fetch_pop  input  1  predicted return: pop top; qualified by fetch_valid.
REQ-010 ras_addr  output  32  current top-of-stack address, combinational from state.
REQ-011 ras_valid  output  1  stack non-empty (count != 0).
REQ-012 br_results  input  branch_results_t  resolved branch info (id, valid, pc, is_call, is_return) from branch unit.
REQ-013 branch_flush  input  1  misprediction of the completing branch; qualified by br_results.valid.

Function
REQ-014 State: RAS_DEPTH x 32 circular storage, top index tos (log2 RAS_DEPTH bits), count (0..RAS_DEPTH).
REQ-015 ras_addr SHALL equal storage[tos]; ras_valid SHALL equal (count != 0); push/pop effects visible the cycle after the operation.
REQ-016 Push only: tos <= tos+1 (mod RAS_DEPTH), storage[tos+1] <= addr, count <= min(count+1, RAS_DEPTH); at full the oldest entry is overwritten silently.
REQ-017 Pop only: if count != 0, tos <= tos-1 (mod RAS_DEPTH), count <= count-1; if count == 0, no state change.
REQ-018 Push and pop same cycle: storage[tos] <= addr, tos unchanged, count <= max(count,1).
REQ-019 On every fetch_valid cycle, checkpoint[fetch_id] <= {tos, count} as of before that cycle's push/pop.
REQ-020 Recovery when br_results.valid & branch_flush: {tos, count} <= checkpoint[br_results.id], then apply the resolved op per REQ-016..018 using is_call (addr = br_results.pc+4) and is_return, all within the same cycle.
REQ-021 Recovery SHALL take priority: fetch push/pop and checkpoint writes in the recovery cycle are ignored.
REQ-022 br_results.valid without branch_flush SHALL not modify state (prediction was correct).
REQ-023 Storage contents overwritten by wrong-path pushes are not restored; only tos/count are recovered.
REQ-024 Arithmetic on tos wraps modulo RAS_DEPTH; count saturates at 0 and RAS_DEPTH.

Reset
REQ-025 rst SHALL set tos to 0 and count to 0, so ras_valid is 0 and ras_addr is don't-care the cycle after reset.
REQ-026 Storage and checkpoint table SHALL not be reset; rst asserted mid-operation overrides push, pop and recovery that cycle.

Structure
REQ-027 ras_ptr_t (tos width) and ras_checkpoint_t ({tos, count}) SHALL live in cva5_types; branch_results_t and id_t reused unchanged.
REQ-028 The checkpoint table SHALL be a sub-module ras_checkpoint_table (MAX_IDS entries, 1 write, 1 async read, no reset).

Verification
REQ-029 Reset, push 0x100, 0x200 -> next cycles ras_addr 0x100 then 0x200, ras_valid 1, count 2.
REQ-030 RAS_DEPTH=8: push 0x10..0x90 (9 pushes) then 8 pops -> ras_addr reads 0x90 down to 0x20, ras_valid 0 after 8th pop; a 9th pop leaves state unchanged.
REQ-031 Empty stack, push+pop same cycle with addr 0x44 -> count 1, ras_addr 0x44; with count 3 -> count stays 3, top replaced.
REQ-032 Push 0x100 (id 1), pop (id 2), push 0x300 (id 3); flush on id 2 with is_return -> tos/count restored to post-id-1 then popped: count 0, ras_valid 0.
REQ-033 Flush on id 1 with is_call, pc 0x1000, simultaneous fetch_push 0x500 -> ras_addr 0x1004, fetch push ignored.
REQ-034 br_results.valid without branch_flush after pushes -> no change in tos, count, ras_addr.
